// File: rtl/cache_repl_ctrl.sv
// Per-set replacement state (valid bits + saturating ages) with a victim-way request engine and flush sequencer.
// Latency: vic_req seen at edge T gives vic_valid from edge T+2; a flush takes exactly N_SETS cycles.
// Backpressure: vic_ready low outside IDLE; the result is held in RESP until vic_ack (or a flush discards it).
module cache_repl_ctrl #(
    parameter int N_WAYS   = 2,
    parameter int N_POW    = 4,
    parameter int N_SETS   = 16,
    parameter int SET_BITS = 4,
    parameter int AGE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_valid,
    input  logic [SET_BITS-1:0] acc_set,
    input  logic [N_POW-1:0]    acc_way,
    input  logic                fill_valid,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [N_POW-1:0]    fill_way,
    input  logic                vic_req,
    input  logic [SET_BITS-1:0] vic_set,
    output logic                vic_ready,
    output logic                vic_valid,
    output logic [N_POW-1:0]    vic_way,
    output logic                vic_empty,
    input  logic                vic_ack,
    input  logic                flush_req,
    output logic                busy,
    output logic                flush_done
);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_RESP, S_FLUSH} state_t;

    // Way count widened by one bit so the range test also works when N_WAYS == 2**N_POW.
    localparam logic [N_POW:0]      WAYS_L   = (N_POW+1)'(N_WAYS);
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(N_SETS - 1);

    state_t              r_state, w_state_nxt;
    logic [N_WAYS-1:0]   r_valid [N_SETS];
    logic [AGE_W-1:0]    r_age   [N_SETS][N_WAYS];
    logic [SET_BITS-1:0] r_vic_set;
    logic [SET_BITS-1:0] r_flush_idx;
    logic [N_POW-1:0]    r_vic_way;
    logic                r_vic_empty;
    logic                r_flush_done;

    logic                w_upd_en;
    logic                w_upd_fill;
    logic [SET_BITS-1:0] w_upd_set;
    logic [N_POW-1:0]    w_upd_way;
    logic [N_WAYS-1:0]   w_new_valid;
    logic [AGE_W-1:0]    w_new_age [N_WAYS];
    logic [N_WAYS-1:0]   w_sel_valid;
    logic [AGE_W-1:0]    w_sel_age [N_WAYS];
    logic [AGE_W-1:0]    w_best_age;
    logic [N_POW-1:0]    w_sel_way;
    logic                w_sel_empty;

    // Pick the single update of this cycle: a fill wins over a hit; out-of-range ways and FLUSH block it.
    always_comb begin
        w_upd_fill = fill_valid;
        w_upd_set  = fill_valid ? fill_set : acc_set;
        w_upd_way  = fill_valid ? fill_way : acc_way;
        w_upd_en   = (r_state != S_FLUSH) &&
                     (fill_valid ? ({1'b0, fill_way} < WAYS_L)
                                 : (acc_valid && ({1'b0, acc_way} < WAYS_L)));
    end

    // New contents of the touched set: touched way to age 0, other valid ways age by one (saturating).
    always_comb begin
        w_new_valid = r_valid[w_upd_set];
        w_new_age   = r_age[w_upd_set];
        for (int k = 0; k < N_WAYS; k++) begin
            if (w_upd_way == N_POW'(k)) begin
                w_new_age[k] = '0;
                if (w_upd_fill) begin
                    w_new_valid[k] = 1'b1;
                end
            end else if (r_valid[w_upd_set][k]) begin
                w_new_age[k] = (r_age[w_upd_set][k] == '1) ? r_age[w_upd_set][k]
                                                           : r_age[w_upd_set][k] + 1'b1;
            end
        end
    end

    // Victim choice on the latched set, seen through any same-cycle update: first empty way, else oldest.
    always_comb begin
        if (w_upd_en && (w_upd_set == r_vic_set)) begin
            w_sel_valid = w_new_valid;
            w_sel_age   = w_new_age;
        end else begin
            w_sel_valid = r_valid[r_vic_set];
            w_sel_age   = r_age[r_vic_set];
        end
        w_sel_way   = '0;
        w_sel_empty = 1'b0;
        w_best_age  = w_sel_age[0];
        for (int k = 0; k < N_WAYS; k++) begin
            if (!w_sel_valid[k] && !w_sel_empty) begin
                w_sel_empty = 1'b1;
                w_sel_way   = N_POW'(k);
            end
        end
        if (!w_sel_empty) begin
            for (int k = 1; k < N_WAYS; k++) begin
                if (w_sel_age[k] > w_best_age) begin
                    w_best_age = w_sel_age[k];
                    w_sel_way  = N_POW'(k);
                end
            end
        end
    end

    // Next-state and handshake outputs; a flush request outranks a new victim request.
    always_comb begin
        w_state_nxt = r_state;
        vic_ready   = 1'b0;
        vic_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                vic_ready = 1'b1;
                if (flush_req) begin
                    w_state_nxt = S_FLUSH;
                end else if (vic_req) begin
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                vic_valid = 1'b1;
                if (vic_ack) begin
                    w_state_nxt = S_IDLE;
                end else if (flush_req) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (r_flush_idx == LAST_SET) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Replacement arrays, latched request, registered result and flush sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                r_valid[s] <= '0;
                for (int k = 0; k < N_WAYS; k++) begin
                    r_age[s][k] <= '0;
                end
            end
            r_vic_set    <= '0;
            r_vic_way    <= '0;
            r_vic_empty  <= 1'b0;
            r_flush_idx  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            if (w_upd_en) begin
                r_valid[w_upd_set] <= w_new_valid;
                r_age[w_upd_set]   <= w_new_age;
            end
            if ((r_state == S_IDLE) && !flush_req && vic_req) begin
                r_vic_set <= vic_set;
            end
            if (r_state == S_SELECT) begin
                r_vic_way   <= w_sel_way;
                r_vic_empty <= w_sel_empty;
            end
            if (r_state == S_FLUSH) begin
                r_valid[r_flush_idx] <= '0;
                for (int k = 0; k < N_WAYS; k++) begin
                    r_age[r_flush_idx][k] <= '0;
                end
                if (r_flush_idx == LAST_SET) begin
                    r_flush_idx  <= '0;
                    r_flush_done <= 1'b1;
                end else begin
                    r_flush_idx <= r_flush_idx + 1'b1;
                end
            end
        end
    end

    assign vic_way    = r_vic_way;
    assign vic_empty  = r_vic_empty;
    assign flush_done = r_flush_done;

endmodule

// File: tb/tb_cache_repl_ctrl.sv
// Randomized bench for cache_repl_ctrl against a set/way array reference model.
// Latency: one update per clock, checks taken 1ns after each rising edge.
// Backpressure: the bench follows the request/ack handshake and flush timing it expects.
module tb_cache_repl_ctrl;

    localparam longint unsigned AGE_MAX = 64'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       acc_valid = 1'b0, fill_valid = 1'b0, vic_req = 1'b0, vic_ack = 1'b0, flush_req = 1'b0;
    logic [3:0] acc_set = '0, fill_set = '0, vic_set = '0;
    logic [3:0] acc_way = '0, fill_way = '0;
    logic       vic_ready, vic_valid, vic_empty, busy, flush_done;
    logic [3:0] vic_way;
    logic       v4_ready, v4_valid, v4_empty, v4_busy, v4_done;
    logic [3:0] v4_way;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model for the default 2-way instance.
    bit              m_valid [16][2];
    longint unsigned m_age   [16][2];
    bit              m_flush = 1'b0;

    cache_repl_ctrl dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .vic_req(vic_req), .vic_set(vic_set), .vic_ready(vic_ready), .vic_valid(vic_valid),
        .vic_way(vic_way), .vic_empty(vic_empty), .vic_ack(vic_ack),
        .flush_req(flush_req), .busy(busy), .flush_done(flush_done)
    );

    // 4-way, 2-bit-age instance used for the saturation / tie-break case.
    cache_repl_ctrl #(.N_WAYS(4), .N_POW(4), .N_SETS(16), .SET_BITS(4), .AGE_W(2)) dut4 (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .vic_req(vic_req), .vic_set(vic_set), .vic_ready(v4_ready), .vic_valid(v4_valid),
        .vic_way(v4_way), .vic_empty(v4_empty), .vic_ack(vic_ack),
        .flush_req(flush_req), .busy(v4_busy), .flush_done(v4_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_clear();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_age[s][w]   = 0;
            end
        end
    endfunction

    function automatic void m_touch(int s, int w, bit is_fill);
        for (int k = 0; k < 2; k++) begin
            if (k == w) m_age[s][k] = 0;
            else if (m_valid[s][k]) m_age[s][k] = (m_age[s][k] >= AGE_MAX) ? AGE_MAX : m_age[s][k] + 1;
        end
        if (is_fill) m_valid[s][w] = 1'b1;
    endfunction

    function automatic int m_victim(int s, output bit empty);
        int best = 0;
        empty = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!m_valid[s][k]) begin
                empty = 1'b1;
                return k;
            end
        end
        for (int k = 1; k < 2; k++) if (m_age[s][k] > m_age[s][best]) best = k;
        return best;
    endfunction

    // One clock: the model absorbs whatever update the bench is driving this cycle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_clear();
        end else if (!m_flush) begin
            if (fill_valid) begin
                if (int'(fill_way) < 2) m_touch(int'(fill_set), int'(fill_way), 1'b1);
            end else if (acc_valid && int'(acc_way) < 2) begin
                m_touch(int'(acc_set), int'(acc_way), 1'b0);
            end
        end
        #1;
    endtask

    task automatic upd(input bit fv, input int fs, input int fw, input bit av, input int as, input int aw);
        fill_valid = fv; fill_set = 4'(fs); fill_way = 4'(fw);
        acc_valid  = av; acc_set  = 4'(as); acc_way  = 4'(aw);
    endtask

    task automatic clr_upd();
        upd(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_upd();
        upd($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 2));
    endtask

    // Caller has flush_req driven; this edge enters FLUSH, then 16 busy cycles and a done pulse.
    task automatic run_flush(input bit rnd);
        tick();
        flush_req = 1'b0;
        vic_req   = 1'b0;
        vic_ack   = 1'b0;
        m_flush   = 1'b1;
        chk("flush_vic_valid", vic_valid, 0);
        for (int i = 0; i < 16; i++) begin
            chk("flush_busy", busy, 1);
            chk("flush_ready", vic_ready, 0);
            chk("flush_done_early", flush_done, 0);
            if (rnd) rand_upd(); else clr_upd();
            flush_req = (i == 5);
            tick();
        end
        flush_req = 1'b0;
        m_clear();
        m_flush = 1'b0;
        chk("flush_end_busy", busy, 0);
        chk("flush_done_pulse", flush_done, 1);
        chk("flush_end_ready", vic_ready, 1);
        clr_upd();
        tick();
        chk("flush_done_once", flush_done, 0);
    endtask

    // Full victim transaction; abort replaces the ack with a flush request in RESP.
    task automatic vic_txn(input int s, input int dly, input bit rnd, input bit abort);
        int ew;
        bit ee;
        chk("txn_ready", vic_ready, 1);
        vic_req = 1'b1;
        vic_set = 4'(s);
        if (rnd) rand_upd(); else clr_upd();
        tick();
        vic_req = 1'b0;
        chk("sel_ready", vic_ready, 0);
        chk("sel_valid", vic_valid, 0);
        if (rnd) rand_upd(); else clr_upd();
        tick();
        ew = m_victim(s, ee);
        chk("resp_valid", vic_valid, 1);
        chk("resp_way", vic_way, 64'(ew));
        chk("resp_empty", vic_empty, 64'(ee));
        for (int i = 0; i < dly; i++) begin
            if (rnd) rand_upd(); else clr_upd();
            tick();
            chk("hold_valid", vic_valid, 1);
            chk("hold_way", vic_way, 64'(ew));
            chk("hold_empty", vic_empty, 64'(ee));
        end
        if (rnd) rand_upd(); else clr_upd();
        if (abort) begin
            flush_req = 1'b1;
            run_flush(rnd);
        end else begin
            vic_ack = 1'b1;
            tick();
            vic_ack = 1'b0;
            chk("ack_valid", vic_valid, 0);
            chk("ack_ready", vic_ready, 1);
        end
        clr_upd();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_upd();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        m_clear();
        do_reset();
        chk("rst_ready", vic_ready, 1);
        chk("rst_valid", vic_valid, 0);
        chk("rst_way", vic_way, 0);
        chk("rst_empty", vic_empty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", flush_done, 0);

        // Empty set, result held five cycles before ack.
        vic_txn(3, 5, 0, 0);

        // Fill both ways of set 3, then hit way 0: way 1 is the oldest.
        upd(1, 3, 0, 0, 0, 0); tick();
        upd(1, 3, 1, 0, 0, 0); tick();
        upd(0, 0, 0, 1, 3, 0); tick();
        clr_upd();
        vic_txn(3, 0, 0, 0);

        // Fill and hit in one cycle: hit dropped, so way 0 ends older than way 1.
        upd(1, 2, 0, 0, 0, 0); tick();
        upd(1, 2, 1, 1, 2, 0); tick();
        clr_upd();
        vic_txn(2, 1, 0, 0);

        // Saturation on the 4-way/2-bit instance; ways 2,3 are out of range for the 2-way one.
        do_reset();
        for (int w = 0; w < 4; w++) begin upd(1, 5, w, 0, 0, 0); tick(); end
        for (int i = 0; i < 4; i++) begin upd(0, 0, 0, 1, 5, 3); tick(); end
        clr_upd();
        vic_req = 1'b1; vic_set = 4'd5; tick();
        vic_req = 1'b0; tick();
        chk("sat4_valid", v4_valid, 1);
        chk("sat4_way", v4_way, 0);
        chk("sat4_empty", v4_empty, 0);
        vic_ack = 1'b1; tick(); vic_ack = 1'b0;
        upd(0, 0, 0, 1, 5, 3); tick();
        clr_upd();
        vic_req = 1'b1; vic_set = 4'd5; tick();
        vic_req = 1'b0; tick();
        chk("sat5_way", v4_way, 0);
        chk("sat5_empty", v4_empty, 0);
        vic_ack = 1'b1; tick(); vic_ack = 1'b0;
        vic_txn(5, 0, 0, 0);

        // Flush requested during RESP discards the result and empties every set.
        upd(1, 7, 0, 0, 0, 0); tick();
        upd(1, 7, 1, 0, 0, 0); tick();
        clr_upd();
        vic_txn(7, 1, 0, 1);
        vic_txn(7, 0, 0, 0);
        vic_txn(5, 0, 0, 0);

        // Flush and victim request in the same IDLE cycle: flush wins.
        upd(1, 1, 0, 0, 0, 0); tick();
        clr_upd();
        vic_req = 1'b1; vic_set = 4'd1; flush_req = 1'b1;
        run_flush(0);
        vic_txn(1, 0, 0, 0);

        // Reset while in SELECT aborts the request and clears state.
        upd(1, 3, 0, 0, 0, 0); tick();
        upd(1, 3, 1, 0, 0, 0); tick();
        clr_upd();
        vic_req = 1'b1; vic_set = 4'd3; tick();
        vic_req = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstsel_ready", vic_ready, 1);
        chk("rstsel_valid", vic_valid, 0);
        chk("rstsel_busy", busy, 0);
        vic_txn(3, 0, 0, 0);

        // Randomized traffic with occasional flushes from IDLE and from RESP.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                rand_upd();
                flush_req = 1'b1;
                run_flush(1);
            end else begin
                vic_txn($urandom_range(0, 3), $urandom_range(0, 3), 1, $urandom_range(0, 24) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
